// File: rtl/key_step_counter.sv
// key_step_counter: debounced pushbutton stepping a 4-bit up/down counter with wrap pulse.
// Define KEY_STEP_SATURATE_EN to saturate at 0/15 instead of wrapping.
module key_step_counter #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       KEY_in,
  input  logic       Dir,
  input  logic       Clear,
  output logic [3:0] V,
  output logic       Wrap,
  output logic       Held
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LIM = CW'(DEBOUNCE_CYCLES);
  typedef enum logic [1:0] {IDLE, WAIT_PRESS, HELD, WAIT_RELEASE} state_t;
  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]    r_sync;
  logic          w_key_s, w_step, w_at_lim;
  logic [3:0]    w_v_step;
  assign w_key_s = r_sync[1];
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) r_sync <= 2'b11;
    else r_sync <= {r_sync[0], KEY_in};
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_step      = 1'b0;
    case (r_state)
      IDLE:
        if (!w_key_s) begin
          w_state_nxt = WAIT_PRESS;
          w_cnt_nxt   = CW'(1);
        end
      WAIT_PRESS:
        if (w_key_s) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LIM) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
          w_step      = 1'b1;
        end else w_cnt_nxt = r_cnt + CW'(1);
      HELD:
        if (w_key_s) begin
          w_state_nxt = WAIT_RELEASE;
          w_cnt_nxt   = CW'(1);
        end
      WAIT_RELEASE:
        if (!w_key_s) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LIM) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else w_cnt_nxt = r_cnt + CW'(1);
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end
  // A step at the limit is the wrap (or saturation) event in both builds
  assign w_at_lim = Dir ? (V == 4'hF) : (V == 4'h0);
`ifdef KEY_STEP_SATURATE_EN
  assign w_v_step = w_at_lim ? V : (Dir ? V + 4'd1 : V - 4'd1);
`else
  assign w_v_step = Dir ? V + 4'd1 : V - 4'd1;
`endif
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      V    <= 4'd0;
      Wrap <= 1'b0;
    end else begin
      Wrap <= w_step && w_at_lim && !Clear;
      V    <= Clear ? 4'd0 : (w_step ? w_v_step : V);
    end
  assign Held = (r_state == HELD) || (r_state == WAIT_RELEASE);
endmodule

// File: tb/tb_key_step_counter.sv
// tb_key_step_counter: scoreboard bench for key_step_counter with DEBOUNCE_CYCLES=4.
module tb_key_step_counter;
  localparam int DEB = 4;
  logic       Clock, Reset, KEY_in, Dir, Clear;
  logic [3:0] V;
  logic       Wrap, Held;
  typedef struct {logic [3:0] v; logic w;} exp_t;
  exp_t       sb[$];
  int         errors = 0, checks = 0;
  logic [3:0] model_v = 4'd0;

  key_step_counter #(.DEBOUNCE_CYCLES(DEB)) dut (
    .Clock(Clock), .Reset(Reset), .KEY_in(KEY_in), .Dir(Dir), .Clear(Clear),
    .V(V), .Wrap(Wrap), .Held(Held)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic pulse_reset();
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    model_v = 4'd0;
  endtask

  task automatic release_key();
    @(negedge Clock);
    KEY_in = 1'b1;
    repeat (DEB + 6) @(posedge Clock);
    #1;
    checks++;
    if (Held !== 1'b0) begin errors++; $display("FAIL release_held: Held=%b expected 0", Held); end
  endtask

  task automatic press(input logic dir, input int hold);
    exp_t e, got;
    int cyc;
    logic [3:0] prev;
    logic hit;
    e.w = dir ? (model_v == 4'hF) : (model_v == 4'h0);
`ifdef KEY_STEP_SATURATE_EN
    e.v = e.w ? model_v : (dir ? model_v + 4'd1 : model_v - 4'd1);
`else
    e.v = dir ? model_v + 4'd1 : model_v - 4'd1;
`endif
    sb.push_back(e);
    prev = V;
    hit = 1'b0;
    cyc = 0;
    @(negedge Clock);
    Dir = dir;
    KEY_in = 1'b0;
    while (!hit && cyc < 30) begin
      @(posedge Clock);
      #1;
      cyc++;
      hit = (V !== prev) || (Wrap === 1'b1);
    end
    got = sb.pop_front();
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL press_timeout: no step after %0d cycles, V=%0d expected %0d", cyc, V, got.v);
    end else begin
      checks += 4;
      if (cyc !== DEB + 3) begin errors++; $display("FAIL step_latency: edge %0d expected %0d", cyc, DEB + 3); end
      if (V !== got.v) begin errors++; $display("FAIL step_value: V=%0d expected %0d", V, got.v); end
      if (Wrap !== got.w) begin errors++; $display("FAIL step_wrap: Wrap=%b expected %b", Wrap, got.w); end
      if (Held !== 1'b1) begin errors++; $display("FAIL step_held: Held=%b expected 1", Held); end
    end
    model_v = got.v;
    @(posedge Clock);
    #1;
    checks++;
    if (Wrap !== 1'b0) begin errors++; $display("FAIL wrap_width: Wrap=%b expected 0", Wrap); end
    repeat (hold) @(posedge Clock);
    #1;
    checks += 2;
    if (V !== model_v) begin errors++; $display("FAIL no_repeat: V=%0d expected %0d", V, model_v); end
    if (Held !== 1'b1) begin errors++; $display("FAIL hold_held: Held=%b expected 1", Held); end
    release_key();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    KEY_in = 1'b1;
    Dir = 1'b1;
    Clear = 1'b0;
    #1;
    checks += 3;
    if (V !== 4'd0) begin errors++; $display("FAIL reset_v: V=%0d expected 0", V); end
    if (Wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: Wrap=%b expected 0", Wrap); end
    if (Held !== 1'b0) begin errors++; $display("FAIL reset_held: Held=%b expected 0", Held); end
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    model_v = 4'd0;
  endtask

  task automatic test_latency();
    press(1'b1, 20);
  endtask

  task automatic test_bounce();
    logic seen_w = 1'b0, seen_h = 1'b0, seen_v = 1'b0;
    logic [3:0] v0 = V;
    logic [7:0] pat = 8'b11000111;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      KEY_in = (i < 8) ? pat[7 - i] : 1'b1;
      @(posedge Clock);
      #1;
      seen_w |= Wrap;
      seen_h |= Held;
      seen_v |= (V !== v0);
    end
    checks += 3;
    if (seen_v) begin errors++; $display("FAIL bounce_v: V=%0d expected %0d", V, v0); end
    if (seen_h) begin errors++; $display("FAIL bounce_held: Held seen 1 expected 0"); end
    if (seen_w) begin errors++; $display("FAIL bounce_wrap: Wrap seen 1 expected 0"); end
  endtask

  task automatic test_down_wrap();
    pulse_reset();
    press(1'b0, 5);
  endtask

  task automatic test_reset_mid();
    exp_t got;
    int cyc = 0;
    press(1'b1, 3);
    @(negedge Clock);
    KEY_in = 1'b0;
    repeat (4) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    #1;
    checks += 2;
    if (V !== 4'd0) begin errors++; $display("FAIL midreset_v: V=%0d expected 0", V); end
    if (Held !== 1'b0) begin errors++; $display("FAIL midreset_held: Held=%b expected 0", Held); end
    sb.push_back('{v: 4'd1, w: 1'b0});
    @(negedge Clock);
    Reset = 1'b0;
    model_v = 4'd0;
    while (V === 4'd0 && cyc < 30) begin
      @(posedge Clock);
      #1;
      cyc++;
    end
    got = sb.pop_front();
    checks += 2;
    if (cyc !== DEB + 3) begin errors++; $display("FAIL midreset_latency: edge %0d expected %0d", cyc, DEB + 3); end
    if (V !== got.v) begin errors++; $display("FAIL midreset_step: V=%0d expected %0d", V, got.v); end
    model_v = got.v;
    repeat (12) @(posedge Clock);
    #1;
    checks++;
    if (V !== model_v) begin errors++; $display("FAIL midreset_single: V=%0d expected %0d", V, model_v); end
    release_key();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) press(1'b1, 2);
  endtask

  task automatic test_clear_on_step();
    pulse_reset();
    for (int i = 0; i < 7; i++) press(1'b1, 1);
    @(negedge Clock);
    Dir = 1'b1;
    KEY_in = 1'b0;
    repeat (DEB + 2) @(posedge Clock);
    @(negedge Clock);
    checks++;
    if (V !== 4'd7) begin errors++; $display("FAIL clear_pre: V=%0d expected 7", V); end
    Clear = 1'b1;
    @(posedge Clock);
    #1;
    checks += 3;
    if (V !== 4'd0) begin errors++; $display("FAIL clear_step_v: V=%0d expected 0", V); end
    if (Wrap !== 1'b0) begin errors++; $display("FAIL clear_step_wrap: Wrap=%b expected 0", Wrap); end
    if (Held !== 1'b1) begin errors++; $display("FAIL clear_step_held: Held=%b expected 1", Held); end
    @(negedge Clock);
    Clear = 1'b0;
    model_v = 4'd0;
    release_key();
  endtask

  task automatic test_clear_dir();
    press(1'b1, 2);
    press(1'b1, 2);
    for (int i = 0; i < 6; i++) begin
      @(negedge Clock);
      Dir = ~Dir;
    end
    @(posedge Clock);
    #1;
    checks++;
    if (V !== model_v) begin errors++; $display("FAIL dir_only: V=%0d expected %0d", V, model_v); end
    @(negedge Clock);
    Clear = 1'b1;
    @(posedge Clock);
    #1;
    checks += 2;
    if (V !== 4'd0) begin errors++; $display("FAIL clear_idle_v: V=%0d expected 0", V); end
    if (Held !== 1'b0) begin errors++; $display("FAIL clear_idle_held: Held=%b expected 0", Held); end
    @(negedge Clock);
    Clear = 1'b0;
    model_v = 4'd0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_bounce();
    test_down_wrap();
    test_reset_mid();
    test_back_to_back();
    test_clear_on_step();
    test_clear_dir();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
